// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: word-addressed RAM behind an IDLE/WAIT/ACCESS handshake with programmable wait states.
// Define SLC3_MMIO_EN to decode address 16'hFFFF as the switch/hex-display I/O register.
module slc3_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] sw,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic [15:0] hex_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  localparam int         DEPTH = 1 << ADDR_W;

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic [15:0]       cap_addr;
  logic [15:0]       cap_wdata;
  logic              cap_we;
  logic [15:0]       ram [DEPTH];
  logic [ADDR_W-1:0] ram_idx;
  logic              is_io;
  logic [15:0]       io_rdata;
  logic              do_access;

  assign ram_idx   = cap_addr[ADDR_W-1:0];
  assign do_access = (state == S_ACCESS);

`ifdef SLC3_MMIO_EN
  assign is_io    = (cap_addr == 16'hFFFF);
  assign io_rdata = sw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_out <= '0;
    end else if (do_access && cap_we && is_io) begin
      hex_out <= cap_wdata;
    end
  end
`else
  logic unused_bits;

  assign is_io       = 1'b0;
  assign io_rdata    = '0;
  assign hex_out     = '0;
  assign unused_bits = ^{sw, cap_addr[15:ADDR_W]};
`endif

  // NOTE: every sequential block uses non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_we    <= we;
            wait_cnt  <= WS;
            busy      <= 1'b1;
            state     <= (WS == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          // Leaving at a count of 1 gives exactly WAIT_STATES cycles in WAIT.
          if (wait_cnt <= 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (do_access && !cap_we) begin
      rdata <= is_io ? io_rdata : ram[ram_idx];
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block memory; its contents survive reset.
  always_ff @(posedge clk) begin
    if (do_access && cap_we && !is_io) begin
      ram[ram_idx] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Scoreboard bench for slc3_mem_responder: two instances (0 and 3 wait states) driven by
// directed and random requests, checked against an array-based memory model.
module tb_slc3_mem_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [15:0] rdata;
    logic [15:0] hex;
    logic [31:0] acc;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req     [2];
  logic        we      [2];
  logic [15:0] addr    [2];
  logic [15:0] wdata   [2];
  logic [15:0] sw;
  logic [15:0] rdata   [2];
  logic [15:0] hex_out [2];
  logic        ready   [2];
  logic        busy    [2];

  int unsigned cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;

  exp_t        sb      [2][$];
  logic [15:0] mem_m   [2][DEPTH];
  logic [15:0] last_rd [2];
  logic [15:0] hex_m   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slc3_mem_responder #(.ADDR_W(AW), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .sw(sw), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .hex_out(hex_out[0])
  );

  slc3_mem_responder #(.ADDR_W(AW), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .sw(sw), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .hex_out(hex_out[1])
  );

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Reference: a transaction is busy from its accept edge until its completion edge,
  // completes WS+1 edges after acceptance, and reports the model's rdata/hex state.
  task automatic monitor_dut(int k);
    exp_t e;
    logic exp_busy;
    exp_busy = 1'b0;
    if (sb[k].size() > 0) exp_busy = (cyc >= sb[k][0].acc) && (cyc < sb[k][0].due);
    check("busy", k, 32'(busy[k]), 32'(exp_busy));
    if (ready[k]) begin
      if (sb[k].size() == 0) begin
        check("ready_unexpected", k, 32'(ready[k]), 32'd0);
      end else begin
        e = sb[k].pop_front();
        check("latency", k, cyc, e.due);
        check("rdata", k, 32'(rdata[k]), 32'(e.rdata));
        check("hex_out", k, 32'(hex_out[k]), 32'(e.hex));
      end
    end else if (sb[k].size() > 0 && cyc >= sb[k][0].due) begin
      check("ready_missing", k, 32'(ready[k]), 32'd1);
      void'(sb[k].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset) for (int k = 0; k < 2; k++) monitor_dut(k);
  end

  task automatic model_apply(int k, logic w, logic [15:0] a, logic [15:0] d);
    logic io;
    int   idx;
    io  = 1'b0;
    idx = int'(a) % DEPTH;
`ifdef SLC3_MMIO_EN
    io = (a == 16'hFFFF);
`endif
    if (w) begin
      if (io) hex_m[k] = d;
      else    mem_m[k][idx] = d;
    end else begin
      last_rd[k] = io ? sw : mem_m[k][idx];
    end
  endtask

  // Called at a negedge; returns at a negedge with req low.
  task automatic issue(int k, logic w, logic [15:0] a, logic [15:0] d, logic spur);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy[k] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy[k]) begin
      check("idle_timeout", k, 32'(busy[k]), 32'd0);
      return;
    end
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    model_apply(k, w, a, d);
    e.acc   = cyc + 1;
    e.due   = cyc + 32'(ws_of(k)) + 2;
    e.rdata = last_rd[k];
    e.hex   = hex_m[k];
    sb[k].push_back(e);
    @(negedge clk);
    if (spur) begin
      req[k]   = 1'b1;
      we[k]    = 1'($urandom_range(0, 1));
      addr[k]  = 16'($urandom);
      wdata[k] = 16'($urandom);
      @(negedge clk);
    end
    req[k] = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    int j;
    int idx;
    if ($urandom_range(0, 9) == 0) return 16'hFFFF;
    j   = int'($urandom_range(0, 15));
    idx = (j < 8) ? j : DEPTH - 16 + j;
    return 16'(int'($urandom_range(0, 63)) * DEPTH + idx);
  endfunction

  task automatic prefill(int k);
    for (int j = 0; j < 16; j++) begin
      int idx;
      idx = (j < 8) ? j : DEPTH - 16 + j;
      issue(k, 1'b1, 16'(idx), 16'($urandom), 1'b0);
    end
  endtask

  task automatic directed(int k);
    issue(k, 1'b1, 16'h0005, 16'h1234, 1'b0);
    issue(k, 1'b0, 16'h0005, 16'h0000, 1'b0);
    issue(k, 1'b1, 16'h0001, 16'hAAAA, 1'b0);
    issue(k, 1'b0, 16'h0001, 16'h0000, 1'b0);
    issue(k, 1'b1, 16'h0403, 16'hBEEF, 1'b1);
    issue(k, 1'b0, 16'h0003, 16'h0000, 1'b1);
    issue(k, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    issue(k, 1'b1, 16'hFFFF, 16'h5A5A, 1'b0);
    issue(k, 1'b0, 16'h03FF, 16'h0000, 1'b0);
  endtask

  task automatic rand_run(int k, int n);
    for (int i = 0; i < n; i++) begin
      issue(k, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb[0].size() > 0 || sb[1].size() > 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", k, 32'(busy[k]), 32'd0);
      check("rst_ready", k, 32'(ready[k]), 32'd0);
      check("rst_rdata", k, 32'(rdata[k]), 32'd0);
      check("rst_hex_out", k, 32'(hex_out[k]), 32'd0);
    end
  endtask

  // A write abandoned by reset must leave RAM untouched; the follow-up read shows old data.
  task automatic reset_test(int k, logic [15:0] a);
    exp_t e;
    req[k] = 1'b1; we[k] = 1'b1; addr[k] = a; wdata[k] = ~mem_m[k][int'(a) % DEPTH];
    e.acc   = cyc + 1;
    e.due   = cyc + 32'(ws_of(k)) + 2;
    e.rdata = last_rd[k];
    e.hex   = hex_m[k];
    sb[k].push_back(e);
    @(negedge clk);
    req[k] = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      sb[i].delete();
      last_rd[i] = '0;
      hex_m[i]   = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(k, 1'b0, a, 16'h0000, 1'b0);
    drain();
  endtask

  initial begin
    reset = 1'b1;
    sw    = '0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      last_rd[k] = '0; hex_m[k] = '0;
    end
    #2 reset = 1'b0;
    #10;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    fork
      prefill(0);
      prefill(1);
    join
    sw = 16'h00C3;
    fork
      directed(0);
      directed(1);
    join
    drain();

    reset_test(0, 16'h0002);
    reset_test(1, 16'h0006);

    sw = 16'($urandom);
    fork
      rand_run(0, 200);
      rand_run(1, 200);
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slc3_mem_responder.md
# slc3_mem_responder

Memory-side responder for the SLC-3 CPU: it accepts the read/write requests the datapath issues from MAR/MDR, applies a configurable number of wait states, and returns read data to the MDR input with a one-cycle `ready` strobe. It holds the word-addressed program/data RAM and, optionally, the memory-mapped switch/hex-display I/O register at 0xFFFF. It sits between the CPU datapath/control and the board I/O.

## Interface
- `ADDR_W`, default 10: RAM index width; RAM holds 2^ADDR_W 16-bit words.
- `WAIT_STATES`, default 1: extra cycles inserted before each access completes (0..15).

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  1  request strobe, sampled only in IDLE
- `we`  in  1  1 = write, 0 = read; sampled with `req`
- `addr`  in  16  word address (MAR)
- `wdata`  in  16  write data (MDR)
- `sw`  in  16  board switches (MMIO read source)
- `rdata`  out  16  read data to MDR input
- `ready`  out  1  one-cycle completion strobe
- `busy`  out  1  transaction in progress; `req` ignored while high
- `hex_out`  out  16  MMIO display register

## Operation
- States: IDLE, WAIT, ACCESS.
- IDLE: on `req`=1, capture `addr`, `we`, `wdata`; load wait counter with WAIT_STATES; go to WAIT if WAIT_STATES>0, else ACCESS. `busy`=1 from the next cycle.
- WAIT: decrement the counter each cycle; go to ACCESS when it reaches 1.
- ACCESS: perform the access on the captured values and go to IDLE on the same edge. That edge also sets `ready`=1 for one cycle and clears `busy`.
- Write: RAM[addr[ADDR_W-1:0]] <= wdata. `rdata` is unchanged.
- Read: `rdata` <= RAM[addr[ADDR_W-1:0]]. `rdata` holds its value until the next read completes.
- Address bits above ADDR_W are ignored, so addresses alias modulo 2^ADDR_W.
- `req` while `busy`=1 is dropped: it is not queued and produces no error.
- `req` in the cycle `ready` is high is accepted, because the FSM is already back in IDLE. Back-to-back transactions are legal.
- RAM contents are not initialised or cleared by reset.

## Timing
- Reset values: state IDLE, `rdata`=0, `ready`=0, `busy`=0, `hex_out`=0, wait counter 0.
- `req` sampled at edge E: `busy`=1 after E. `ready`=1 and `busy`=0 after edge E+WAIT_STATES+1; `ready` returns to 0 after E+WAIT_STATES+2.
- Latency from request to `ready` is WAIT_STATES+1 cycles. Minimum request spacing is WAIT_STATES+1 cycles.
- `rdata` is valid in the cycle `ready`=1 and remains stable afterwards.
- Reset asserted mid-transaction: the transaction is abandoned and all outputs take their reset values immediately. A write whose ACCESS edge has not occurred is not committed.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `SLC3_MMIO_EN`.
- Defined:
  - Captured address 16'hFFFF is decoded as I/O and the RAM is not touched.
  - Read returns `sw`.
  - Write loads `hex_out` <= wdata.
- Undefined:
  - 16'hFFFF is an ordinary RAM address that aliases to RAM[2^ADDR_W-1].
  - `hex_out` is tied to 0.
  - `sw` is unused.

## Test plan
- Reset released, WAIT_STATES=1: write 16'h1234 to 16'h0005, then read 16'h0005. Required: each `ready` arrives 2 cycles after its `req`; `rdata`=16'h1234.
- WAIT_STATES=0, back-to-back: write 16'hAAAA to 16'h0001, then issue a read of 16'h0001 in the `ready` cycle. Required: the read is accepted and `rdata`=16'hAAAA one cycle later.
- `req` pulsed during WAIT (WAIT_STATES=3). Required: exactly one `ready`, and the second request has no effect on RAM or `rdata`.
- ADDR_W=10: write 16'hBEEF to 16'h0403, read 16'h0003. Required: `rdata`=16'hBEEF (aliasing).
- MMIO with `SLC3_MMIO_EN` defined: `sw`=16'h00C3, read 16'hFFFF; then write 16'h5A5A to 16'hFFFF. Required: `rdata`=16'h00C3, `hex_out`=16'h5A5A, RAM[1023] unchanged.
  - Same stimulus without the macro. Required: `hex_out` stays 0; a read of 16'h03FF returns 16'h5A5A.
- Reset asserted one cycle after a write `req` (WAIT_STATES=2). Required: `busy`/`ready`/`rdata`/`hex_out` are 0 immediately, and a later read of that address shows the old RAM contents.
